// File: rtl/alu_control_mdu_if.sv
// ---------------------------------------------------------------------------
// alu_control_mdu_if
//   Bundles the control-unit / operand inputs and the ALU-control and
//   multiply/divide result outputs of alu_control_mdu.
//
//   Parameter WIDTH : operand / HI / LO width.
//   master : driver side (control unit, register file, bench)
//   slave  : alu_control_mdu
//
//   Signals (master -> slave):
//     ALUOp[1:0]     operation class
//     Function[5:0]  instruction bits 5:0
//     Issue          decoded instruction valid this cycle
//     A, B           rs / rt operands
//   Signals (slave -> master):
//     ALUControl[3:0] ALU operation select
//     JR              jump-register decode
//     Busy            multiply/divide in progress
//     Stall           pipeline hold request
//     Done            one-cycle pulse when HI/LO written
//     DivZero         qualifies Done: divisor was zero
//     HI, LO          result registers
//     HiLoData        MFHI / MFLO read data
// ---------------------------------------------------------------------------
interface alu_control_mdu_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       ALUOp;
   logic [5:0]       Function;
   logic             Issue;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;

   logic [3:0]       ALUControl;
   logic             JR;
   logic             Busy;
   logic             Stall;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic [WIDTH-1:0] HiLoData;

   modport master (
      output ALUOp, Function, Issue, A, B,
      input  ALUControl, JR, Busy, Stall, Done, DivZero, HI, LO, HiLoData
   );

   modport slave (
      input  ALUOp, Function, Issue, A, B,
      output ALUControl, JR, Busy, Stall, Done, DivZero, HI, LO, HiLoData
   );
endinterface

// File: rtl/alu_control_mdu.sv
// ---------------------------------------------------------------------------
// alu_control_mdu
//   ALU control decoder plus an iterative multiply/divide unit with HI/LO.
//
//   Ports:
//     clk    : clock, all state updates on rising edge
//     reset  : synchronous, active-high
//     bus    : alu_control_mdu_if.slave (ALUOp, Function, Issue, A, B in;
//              ALUControl, JR, Busy, Stall, Done, DivZero, HI, LO,
//              HiLoData out)
//
//   Parameter WIDTH : operand width, even and >= 8.
//
//   Build option: define ALU_CONTROL_MDU_DIV_EN to include the divider.
//   Without it DIV/DIVU decode as no-ops and DivZero is tied low.
//
//   Sequencing: IDLE -> ITER (WIDTH cycles, one bit each) -> FIX (sign
//   correction, HI/LO write) -> IDLE with Done pulsing in the following
//   cycle. Multiply and divide both iterate on operand magnitudes.
// ---------------------------------------------------------------------------
module alu_control_mdu #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               reset,
   alu_control_mdu_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_ITER = 2'b01;
   localparam logic [1:0] S_FIX  = 2'b10;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               md_dec;
   logic               mf_dec;
   logic               sel_hi;
   logic               sel_lo;
   logic               op_signed;
   logic               accept;
   logic               last_iter;
   logic               done_r;
   logic               neg_p;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   hi_nxt;
   logic [WIDTH-1:0]   lo_nxt;
`ifdef ALU_CONTROL_MDU_DIV_EN
   logic               op_div;
   logic               is_div;
   logic               neg_r;
   logic               div_zero_p;
   logic               dz_r;
   logic [WIDTH-1:0]   a_keep;
   logic [WIDTH:0]     div_trial;
`endif

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
      return neg ? -v : v;
   endfunction

   // Control decode
   always_comb begin
      bus.ALUControl = 4'b0000;
      bus.JR         = 1'b0;
      md_dec         = 1'b0;
      mf_dec         = 1'b0;
      sel_hi         = 1'b0;
      sel_lo         = 1'b0;
      op_signed      = 1'b0;
`ifdef ALU_CONTROL_MDU_DIV_EN
      op_div         = 1'b0;
`endif
      case (bus.ALUOp)
         2'b00: bus.ALUControl = 4'b0010;
         2'b01: bus.ALUControl = 4'b0110;
         default: begin
            case (bus.Function)
               6'b100100: bus.ALUControl = 4'b0000;
               6'b100101: bus.ALUControl = 4'b0001;
               6'b100000: bus.ALUControl = 4'b0010;
               6'b100010: bus.ALUControl = 4'b0110;
               6'b101010: bus.ALUControl = 4'b0111;
               6'b100111: bus.ALUControl = 4'b1100;
               6'b001000: bus.JR         = 1'b1;
               6'b011000: begin md_dec = 1'b1; op_signed = 1'b1; end
               6'b011001: md_dec = 1'b1;
`ifdef ALU_CONTROL_MDU_DIV_EN
               6'b011010: begin md_dec = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
               6'b011011: begin md_dec = 1'b1; op_div = 1'b1; end
`endif
               6'b010000: begin mf_dec = 1'b1; sel_hi = 1'b1; end
               6'b010010: begin mf_dec = 1'b1; sel_lo = 1'b1; end
               default: ;
            endcase
         end
      endcase
   end

   // Busy is low only in IDLE, so IDLE alone qualifies acceptance.
   assign accept    = (state == S_IDLE) && bus.Issue && md_dec;
   assign last_iter = (cnt == CW'(WIDTH-1));

   assign mag_a = cond_neg(bus.A, op_signed & bus.A[WIDTH-1]);
   assign mag_b = cond_neg(bus.B, op_signed & bus.B[WIDTH-1]);

   // Shift-add step: upper half accumulates, product shifts right.
   assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

`ifdef ALU_CONTROL_MDU_DIV_EN
   // Restoring step: remainder shifted with the next dividend bit, minus
   // divisor; a clear MSB means the subtraction fits.
   assign div_trial = prod[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
`endif

   // Operand latch and iteration datapath
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: begin
            if (accept) begin
               neg_p <= op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`ifdef ALU_CONTROL_MDU_DIV_EN
               neg_r      <= op_signed & bus.A[WIDTH-1];
               is_div     <= op_div;
               a_keep     <= bus.A;
               div_zero_p <= (bus.B == '0);
               if (op_div) begin
                  prod  <= {{WIDTH{1'b0}}, mag_a};
                  mcand <= mag_b;
               end else
`endif
               begin
                  prod  <= {{WIDTH{1'b0}}, mag_b};
                  mcand <= mag_a;
               end
            end
         end
         S_ITER: begin
`ifdef ALU_CONTROL_MDU_DIV_EN
            if (is_div) begin
               if (!div_trial[WIDTH])
                  prod <= {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
               else
                  prod <= {prod[2*WIDTH-2:0], 1'b0};
            end else
`endif
            prod <= {mul_sum, prod[WIDTH-1:1]};
         end
         default: ;
      endcase
   end

   // Sign fix-up of the magnitude result
   always_comb begin
      {hi_nxt, lo_nxt} = cond_neg2(prod, neg_p);
`ifdef ALU_CONTROL_MDU_DIV_EN
      if (is_div) begin
         hi_nxt = cond_neg(prod[2*WIDTH-1:WIDTH], neg_r);
         lo_nxt = cond_neg(prod[WIDTH-1:0], neg_p);
         if (div_zero_p) begin
            hi_nxt = a_keep;
            lo_nxt = '1;
         end
      end
`endif
   end

   // Sequencer and HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
`ifdef ALU_CONTROL_MDU_DIV_EN
         dz_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef ALU_CONTROL_MDU_DIV_EN
         dz_r   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_ITER;
                  cnt   <= '0;
               end
            end
            S_ITER: begin
               cnt <= cnt + 1'b1;
               if (last_iter) state <= S_FIX;
            end
            S_FIX: begin
               hi_r   <= hi_nxt;
               lo_r   <= lo_nxt;
               done_r <= 1'b1;
`ifdef ALU_CONTROL_MDU_DIV_EN
               dz_r   <= is_div & div_zero_p;
`endif
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.Busy     = (state != S_IDLE);
   assign bus.Stall    = bus.Busy & bus.Issue & (md_dec | mf_dec);
   assign bus.Done     = done_r;
`ifdef ALU_CONTROL_MDU_DIV_EN
   assign bus.DivZero  = dz_r;
`else
   assign bus.DivZero  = 1'b0;
`endif
   assign bus.HI       = hi_r;
   assign bus.LO       = lo_r;
   assign bus.HiLoData = sel_hi ? hi_r : (sel_lo ? lo_r : '0);

endmodule

// File: tb/tb_alu_control_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_control_mdu
//   Randomized self-checking bench for alu_control_mdu (WIDTH=32). Expected
//   results come from plain 64-bit arithmetic in the bench. Honours the
//   ALU_CONTROL_MDU_DIV_EN build option: without it DIV/DIVU are expected
//   to be ignored.
// ---------------------------------------------------------------------------
module tb_alu_control_mdu;

   localparam int WIDTH = 32;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

`ifdef ALU_CONTROL_MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_control_mdu_if #(.WIDTH(WIDTH)) bus ();

   alu_control_mdu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {JR, ALUControl} from the opcode table
   function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return 5'b0_0010;
      if (op == 2'b01) return 5'b0_0110;
      case (fn)
         6'b100100: return 5'b0_0000;
         6'b100101: return 5'b0_0001;
         6'b100000: return 5'b0_0010;
         6'b100010: return 5'b0_0110;
         6'b101010: return 5'b0_0111;
         6'b100111: return 5'b0_1100;
         6'b001000: return 5'b1_0000;
         default:   return 5'b0_0000;
      endcase
   endfunction

   // {HI, LO} from plain arithmetic
   function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (fn)
         F_MULT:  return 64'(sa * sb);
         F_MULTU: return ua * ub;
         F_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Present an MD op for exactly one accept edge, then scramble inputs.
   task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.Issue    = 1'b1;
      bus.ALUOp    = 2'b10;
      bus.Function = fn;
      bus.A        = a;
      bus.B        = b;
      @(posedge clk);
      #1;
      bus.Issue    = 1'b0;
      bus.ALUOp    = 2'($urandom);
      bus.Function = 6'($urandom);
      bus.A        = $urandom;
      bus.B        = $urandom;
   endtask

   // Cycles after the accept edge until Done (k=1 is the cycle after it).
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus.Busy) busy_cnt++;
         if (bus.Done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic do_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b);
      logic [63:0] r;
      int          lat, bc;
      bit          is_div;
      is_div = (fn == F_DIV) || (fn == F_DIVU);
      issue(fn, a, b);
      if (is_div && !DIV_EN) begin
         @(negedge clk);
         chk({tag, " noop busy"}, 64'(bus.Busy), 64'd0);
         chk({tag, " noop hi"}, 64'(bus.HI), 64'(exp_hi));
         chk({tag, " noop lo"}, 64'(bus.LO), 64'(exp_lo));
         return;
      end
      r = ref_md(fn, a, b);
      wait_done(lat, bc);
      chk({tag, " latency"}, 64'(lat), 64'(WIDTH + 2));
      chk({tag, " busy cycles"}, 64'(bc), 64'(WIDTH + 1));
      chk({tag, " hi"}, 64'(bus.HI), 64'(r[63:32]));
      chk({tag, " lo"}, 64'(bus.LO), 64'(r[31:0]));
      chk({tag, " divzero"}, 64'(bus.DivZero), 64'(is_div && (b == 0)));
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      @(negedge clk);
      chk({tag, " done pulse"}, 64'(bus.Done), 64'd0);
   endtask

   initial begin
      logic [63:0] r;
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [5:0]  dec_tab [8];
      int          lat, bc, bad, dn;
      bit          seen;

      dec_tab = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                  6'b101010, 6'b100111, 6'b001000, 6'b111111};

      bus.Issue = 1'b0; bus.ALUOp = 2'b00; bus.Function = '0;
      bus.A = '0; bus.B = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst busy", 64'(bus.Busy), 64'd0);
      chk("rst done", 64'(bus.Done), 64'd0);
      chk("rst divzero", 64'(bus.DivZero), 64'd0);
      chk("rst hi", 64'(bus.HI), 64'd0);
      chk("rst lo", 64'(bus.LO), 64'd0);

      // Decode: table entries at ALUOp=10, then random ALUOp/Function
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         op = (i < 8) ? 2'b10 : 2'($urandom);
         fn = (i < 8) ? dec_tab[i] : 6'($urandom);
         bus.ALUOp = op;
         bus.Function = fn;
         #1;
         chk("decode", {59'd0, bus.JR, bus.ALUControl}, {59'd0, ref_dec(op, fn)});
      end

      // Directed arithmetic cases
      do_md("mult neg", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
      do_md("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_md("div neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      do_md("divu zero", F_DIVU, 32'h0000_0007, 32'h0000_0000);
      do_md("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      do_md("div zero s", F_DIV, 32'h8000_0005, 32'h0000_0000);

      // Randomized MD ops
      for (int i = 0; i < 16; i++) begin
         fn = F_MULT + 6'($urandom_range(0, 3));
         do_md("rand md", fn, pick(), pick());
      end

      // MFLO issued 5 cycles after MULT: stall until the Done cycle
      r = ref_md(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus.Issue = 1'b1; bus.ALUOp = 2'b10; bus.Function = F_MFLO;
      #1;
      bad = 0;
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (bus.Done) begin
            seen = 1'b1;
            break;
         end
         if (!bus.Stall) bad++;
         @(negedge clk);
         #1;
      end
      chk("mflo done seen", 64'(seen), 64'd1);
      chk("mflo stall while busy", 64'(bad), 64'd0);
      chk("mflo stall in done", 64'(bus.Stall), 64'd0);
      chk("mflo data", 64'(bus.HiLoData), 64'(r[31:0]));
      bus.Function = F_MFHI;
      #1;
      chk("mfhi data", 64'(bus.HiLoData), 64'(r[63:32]));
      bus.Function = 6'b100000;
      #1;
      chk("hilodata other", 64'(bus.HiLoData), 64'd0);
      bus.Issue = 1'b0;
      exp_hi = r[63:32];
      exp_lo = r[31:0];

      // MD issue held through Busy is ignored, then accepted in the Done cycle
      r = ref_md(F_MULTU, 32'hDEAD_BEEF, 32'h0000_1001);
      issue(F_MULTU, 32'hDEAD_BEEF, 32'h0000_1001);
      bus.Issue = 1'b1; bus.ALUOp = 2'b10; bus.Function = F_MULT;
      bus.A = 32'hFFFF_FF00; bus.B = 32'h0000_0100;
      wait_done(lat, bc);
      chk("b2b first latency", 64'(lat), 64'(WIDTH + 2));
      chk("b2b first hi", 64'(bus.HI), 64'(r[63:32]));
      chk("b2b first lo", 64'(bus.LO), 64'(r[31:0]));
      chk("b2b stall in done", 64'(bus.Stall), 64'd0);
      @(negedge clk);
      chk("b2b second accepted", 64'(bus.Busy), 64'd1);
      bus.Issue = 1'b0;
      r = ref_md(F_MULT, 32'hFFFF_FF00, 32'h0000_0100);
      wait_done(lat, bc);
      chk("b2b second latency", 64'(lat), 64'(WIDTH + 1));
      chk("b2b second hi", 64'(bus.HI), 64'(r[63:32]));
      chk("b2b second lo", 64'(bus.LO), 64'(r[31:0]));

      // Reset mid-sequence; decode and DIV stall checks while busy
      issue(F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      repeat (5) @(negedge clk);
      bus.Issue = 1'b1; bus.ALUOp = 2'b10; bus.Function = F_DIV;
      #1;
      chk("div stall while busy", 64'(bus.Stall), 64'(DIV_EN));
      bus.ALUOp = 2'b01;
      #1;
      chk("aluop01 busy", 64'(bus.ALUControl), 64'h6);
      chk("aluop01 no stall", 64'(bus.Stall), 64'd0);
      bus.Issue = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst busy", 64'(bus.Busy), 64'd0);
      chk("midrst hi", 64'(bus.HI), 64'd0);
      chk("midrst lo", 64'(bus.LO), 64'd0);
      dn = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.Done) dn++;
      end
      chk("midrst no done", 64'(dn), 64'd0);
      exp_hi = '0;
      exp_lo = '0;

      // One more operation after reset recovers normally
      do_md("post rst mult", F_MULT, 32'h0000_0003, 32'hFFFF_FFFB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
